ecpu_ifetch: RTL and testbench

- Instruction-fetch stage between the 256-entry instruction ROM and the execute/decode stage.
- Owns the program counter, drives the ROM address, and captures the combinational 42-bit ROM word into a one-entry instruction register.
- Splits the captured word into fields and presents it to execute with a valid/ready handshake.
- Handles jump redirects from execute and stops fetching after the EXIT instruction is accepted.

---
 rtl/ecpu_ifetch.sv | 90 +++++++++
 tb/tb_ecpu_ifetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecpu_ifetch.sv
// Instruction-fetch stage: owns the PC, captures the ROM word into a one-entry
// instruction register and hands it to execute over a valid/ready handshake.
module ecpu_ifetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = 42,
  parameter logic [4:0]        EXIT_OP  = 5'b11111,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              op_src_imm,
  output logic [4:0]        op_code,
  output logic [7:0]        op_jtarget,
  output logic [2:0]        op_dst,
  output logic              op_flag,
  output logic [23:0]       op_imm,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_p0;
  logic [INST_W-1:0]   ir_p1;
  logic [ADDR_W-1:0]   pc_p1;
  logic                vld_p1;
  logic                run;
  logic                take;
  logic                exit_take;
  logic                fetch_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (exit_take) state_nxt = HALTED;
  end

  // Redirect beats both the handshake and an EXIT acceptance in the same cycle.
  always_comb begin
    run       = (state == RUN);
    halted    = (state == HALTED);
    take      = vld_p1 && inst_ready;
    exit_take = run && !jmp_en && take && (op_code == EXIT_OP);
    fetch_en  = run && !jmp_en && (!vld_p1 || inst_ready) && !exit_take;
  end

  // Stage p0 -> p1: PC drives the ROM, the returned word lands in the IR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0  <= RESET_PC;
      ir_p1  <= '0;
      pc_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (run) begin
      if (jmp_en) begin
        pc_p0  <= jmp_addr;
        vld_p1 <= 1'b0;
      end else if (exit_take) begin
        vld_p1 <= 1'b0;
      end else if (fetch_en) begin
        ir_p1  <= rom_data;
        pc_p1  <= pc_p0;
        vld_p1 <= 1'b1;
        pc_p0  <= pc_p0 + ADDR_W'(1);
      end
    end
  end

  assign rom_addr   = pc_p0;
  assign inst_valid = vld_p1;
  assign inst_pc    = pc_p1;
  assign op_src_imm = ir_p1[41];
  assign op_code    = ir_p1[40:36];
  assign op_jtarget = ir_p1[35:28];
  assign op_dst     = ir_p1[27:25];
  assign op_flag    = ir_p1[24];
  assign op_imm     = ir_p1[23:0];

endmodule

// File: tb/tb_ecpu_ifetch.sv
// Bench for ecpu_ifetch: a program-order reference model predicts the stream
// of handed-over instructions; a negedge monitor pops and compares.
module tb_ecpu_ifetch;
  localparam int         AW      = 8;
  localparam int         IW      = 42;
  localparam logic [4:0] EXIT_OP = 5'b11111;
  localparam logic [7:0] RST_PC  = 8'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, inst_ready, jmp_en;
  logic [AW-1:0] jmp_addr;
  logic [AW-1:0] rom_addr, inst_pc;
  logic [IW-1:0] rom_data;
  logic          inst_valid, op_src_imm, op_flag, halted;
  logic [4:0]    op_code;
  logic [7:0]    op_jtarget;
  logic [2:0]    op_dst;
  logic [23:0]   op_imm;

  logic [AW-1:0] w_rom_addr, w_inst_pc;
  logic [IW-1:0] w_rom_data;
  logic          w_inst_valid, w_op_src_imm, w_op_flag, w_halted;
  logic [4:0]    w_op_code;
  logic [7:0]    w_op_jtarget;
  logic [2:0]    w_op_dst;
  logic [23:0]   w_op_imm;

  logic [IW-1:0] rom [256];
  assign rom_data   = rom[rom_addr];
  assign w_rom_data = rom[w_rom_addr];

  ecpu_ifetch #(.ADDR_W(AW), .INST_W(IW), .EXIT_OP(EXIT_OP), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
    .op_src_imm(op_src_imm), .op_code(op_code), .op_jtarget(op_jtarget),
    .op_dst(op_dst), .op_flag(op_flag), .op_imm(op_imm),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr), .halted(halted)
  );

  ecpu_ifetch #(.ADDR_W(AW), .INST_W(IW), .EXIT_OP(EXIT_OP), .RESET_PC(8'd254)) u_wrap (
    .clk(clk), .rst_n(rst_n), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst_pc(w_inst_pc),
    .op_src_imm(w_op_src_imm), .op_code(w_op_code), .op_jtarget(w_op_jtarget),
    .op_dst(w_op_dst), .op_flag(w_op_flag), .op_imm(w_op_imm),
    .jmp_en(1'b0), .jmp_addr(8'd0), .halted(w_halted)
  );

  int n_cmp = 0;
  int n_err = 0;
  int hs_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] dut_word();
    return {op_src_imm, op_code, op_jtarget, op_dst, op_flag, op_imm};
  endfunction

  // Reference model: the next program-order address execute should receive.
  logic [AW-1:0]       exp_q[$];
  bit                  started = 0, m_halted = 0, rst_chk = 0, stall_prev = 0;
  int                  jstage = 0;
  logic [AW-1:0]       jtarget, halt_addr;
  logic [AW+IW+AW-1:0] snap;

  always @(negedge clk) begin
    logic [AW-1:0] e;
    logic [AW-1:0] nxt;
    if (!rst_n) begin
      started    = 1;
      m_halted   = 0;
      rst_chk    = 1;
      stall_prev = 0;
      jstage     = 1;
      jtarget    = RST_PC;
      exp_q.delete();
      exp_q.push_back(RST_PC);
    end else if (started) begin
      if (rst_chk) begin
        check("reset_valid",    64'(inst_valid), 64'd0);
        check("reset_rom_addr", 64'(rom_addr),   64'(RST_PC));
        check("reset_inst_pc",  64'(inst_pc),    64'd0);
        check("reset_fields",   64'(dut_word()), 64'd0);
        rst_chk = 0;
      end
      if (m_halted) begin
        check("halted_flag",     64'(halted),     64'd1);
        check("halted_valid",    64'(inst_valid), 64'd0);
        check("halted_rom_addr", 64'(rom_addr),   64'(halt_addr));
      end else begin
        check("not_halted", 64'(halted), 64'd0);
      end
      if (jstage == 1) begin
        check("flush_valid", 64'(inst_valid), 64'd0);
        jstage = 2;
      end else if (jstage == 2) begin
        check("target_valid", 64'(inst_valid), 64'd1);
        check("target_pc",    64'(inst_pc),    64'(jtarget));
        jstage = 0;
      end
      if (stall_prev)
        check("stall_hold", 64'({inst_valid, inst_pc, dut_word(), rom_addr}), 64'({1'b1, snap}));
      if (inst_valid && !m_halted) begin
        nxt = inst_pc + 8'd1;
        check("rom_addr_ahead", 64'(rom_addr), 64'(nxt));
      end

      stall_prev = 0;
      if (m_halted) begin
      end else if (jmp_en) begin
        exp_q.delete();
        exp_q.push_back(jmp_addr);
        jstage  = 1;
        jtarget = jmp_addr;
      end else if (inst_valid && inst_ready) begin
        hs_count++;
        check("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("handover_pc",     64'(inst_pc),    64'(e));
          check("handover_fields", 64'(dut_word()), 64'(rom[e]));
          nxt = e + 8'd1;
          if (rom[e][40:36] == EXIT_OP) begin
            m_halted  = 1;
            halt_addr = nxt;
          end else begin
            exp_q.push_back(nxt);
          end
        end
      end else if (inst_valid) begin
        stall_prev = 1;
        snap = {inst_pc, dut_word(), rom_addr};
      end
    end
  end

  // Second instance starts near the top of the address space to exercise wrap.
  initial begin
    @(posedge rst_n);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("wrap_valid", 64'(w_inst_valid), 64'd1);
      check("wrap_pc",    64'(w_inst_pc),    64'((254 + i) % 256));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] r;
    for (int a = 0; a < 256; a++) begin
      r = {$urandom(), $urandom()};
      if (r[40:36] == EXIT_OP) r[40:36] = 5'd30;
      rom[a] = r[41:0];
    end
    rom[0] = {1'b1, 5'd4, 8'd1, 3'd0, 1'b0, 24'h000044};
    rom[1] = {1'b0, 5'd7, 8'h22, 3'd5, 1'b1, 24'hABCDEF};
    rom[2] = {1'b1, 5'd9, 8'h80, 3'd2, 1'b0, 24'h123456};
    rom[3] = {1'b0, 5'd1, 8'hFF, 3'd7, 1'b1, 24'h000001};
    rom[5] = {1'b0, EXIT_OP, 8'h00, 3'd0, 1'b0, 24'h000000};

    rst_n = 1'b0; inst_ready = 1'b1; jmp_en = 1'b0; jmp_addr = '0;
    step(); step();
    rst_n = 1'b1;

    step();
    check("first_valid", 64'(inst_valid), 64'd1);
    check("first_pc",    64'(inst_pc),    64'd0);
    check("ex_src_imm",  64'(op_src_imm), 64'd1);
    check("ex_code",     64'(op_code),    64'd4);
    check("ex_jtarget",  64'(op_jtarget), 64'd1);
    check("ex_imm",      64'(op_imm),     64'h44);
    step();
    check("stream_pc1", 64'(inst_pc), 64'd1);
    step();
    check("stream_pc2", 64'(inst_pc), 64'd2);

    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",       64'(inst_pc),  64'd2);
      check("stall_rom_addr", 64'(rom_addr), 64'd3);
    end
    inst_ready = 1'b1;
    step();
    check("after_stall_pc", 64'(inst_pc), 64'd3);
    step(); step(); step();
    check("halt_flag",     64'(halted),     64'd1);
    check("halt_valid",    64'(inst_valid), 64'd0);
    check("halt_rom_addr", 64'(rom_addr),   64'd6);

    jmp_en = 1'b1; jmp_addr = 8'd0;
    step();
    jmp_en = 1'b0;
    step();
    check("halt_jmp_ignored", 64'(rom_addr), 64'd6);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_halt_flag",     64'(halted),   64'd0);
    check("rst_halt_rom_addr", 64'(rom_addr), 64'(RST_PC));
    step(); step();
    check("resume_pc1", 64'(inst_pc), 64'd1);

    inst_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; inst_ready = 1'b1;
    check("rst_stall_valid", 64'(inst_valid), 64'd0);
    step(); step(); step(); step();
    check("pre_jump_pc", 64'(inst_pc), 64'd3);

    jmp_en = 1'b1; jmp_addr = 8'h40;
    step();
    jmp_en = 1'b0;
    check("jump_flush", 64'(inst_valid), 64'd0);
    step();
    check("jump_target_valid", 64'(inst_valid), 64'd1);
    check("jump_target_pc",    64'(inst_pc),    64'h40);

    for (int c = 0; c < 1500; c++) begin
      if ((halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; jmp_en = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        inst_ready = ($urandom_range(0, 3) != 0);
        jmp_en     = ($urandom_range(0, 11) == 0);
        jmp_addr   = 8'($urandom_range(8, 250));
        step();
      end
    end
    jmp_en = 1'b0;
    step(); step();

    check("progress", 64'(hs_count > 100), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
